mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 33 +++
 rtl/mem_byte_lane.sv | 35 +++
 rtl/mem_access_unit.sv | 123 ++++++++++++
 tb/tb_mem_access_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the load/store unit: access size, FSM state and small decode helpers.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic {
    IDLE     = 1'b0,
    MERGE_WR = 1'b1
  } state_e;

  // Encoding 2'b11 is treated as a word access.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  // Byte offset within the word after forcing natural alignment.
  function automatic logic [1:0] lane_offset(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return addr_lo;
      SZ_HALF: return {addr_lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational lane logic: merges store data into a read word and extracts/extends load data.
module mem_byte_lane
  import mem_access_pkg::*;
(
  input  size_e       size,
  input  logic        unsigned_ld,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    merged = rdata;
    unique case (size)
      SZ_BYTE: merged[{offset, 3'b000} +: 8]        = wdata[7:0];
      SZ_HALF: merged[{offset[1], 4'b0000} +: 16]   = wdata[15:0];
      default: merged = wdata;
    endcase
  end

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    unique case (size)
      SZ_BYTE: load_data = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: word stores in one cycle, sub-word stores via read-merge-write.
// Optional MEM_MISALIGN_TRAP_EN adds misalignment detection and the misalign output.
module mem_access_unit
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  state_e      state_q;
  logic [31:0] merged_q;
  logic [29:0] addr_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;

  size_e       size;
  logic        do_load, do_store, misaligned;
  logic [31:0] merge_data, load_data;

  assign size     = decode_size(req_size);
  assign do_load  = req_valid & req_load & ~req_store;
  assign do_store = req_valid & req_store & ~req_load;

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misaligned = ((size == SZ_HALF) & req_addr[0]) |
                      ((size == SZ_WORD) & (req_addr[1:0] != 2'b00));
  assign misalign   = misalign_q;
`else
  assign misaligned = 1'b0;
`endif

  mem_byte_lane u_lane (
    .size        (size),
    .unsigned_ld (req_unsigned),
    .offset      (lane_offset(size, req_addr[1:0])),
    .wdata       (req_wdata),
    .rdata       (mem_rdata),
    .merged      (merge_data),
    .load_data   (load_data)
  );

  always_comb begin
    stall     = 1'b0;
    mem_write = 1'b0;
    mem_addr  = {req_addr[31:2], 2'b00};
    mem_wdata = req_wdata;
    if (!reset) begin
      if (state_q == MERGE_WR) begin
        mem_write = 1'b1;
        mem_addr  = {addr_q, 2'b00};
        mem_wdata = merged_q;
      end else if (do_store && !misaligned) begin
        if (size == SZ_WORD) mem_write = 1'b1;
        else                 stall     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      merged_q    <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q  <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (do_load || do_store) begin
            if (misaligned) begin
`ifdef MEM_MISALIGN_TRAP_EN
              misalign_q <= 1'b1;
`endif
              if (do_load) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= '0;
              end
            end else if (do_load) begin
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_data;
            end else if (size != SZ_WORD) begin
              merged_q <= merge_data;
              addr_q   <= req_addr[31:2];
              state_q  <= MERGE_WR;
            end
          end
        end
        MERGE_WR: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a small word-addressed memory model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_load, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, mem_write;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  logic [31:0] mem [0:63];
  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt, pulse_cnt;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_load     (req_load),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign     (misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply a request on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic v, input logic ld, input logic st, input logic [1:0] sz,
                       input logic un, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = v; req_load = ld; req_store = st; req_size = sz;
    req_unsigned = un; req_addr = a; req_wdata = d;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[8]  = 32'h11223344;
    mem[12] = 32'h8000FF80;
    reset = 1'b1;
    req_valid = 1'b1; req_load = 1'b0; req_store = 1'b1; req_size = 2'b10;
    req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = 32'h0BADF00D;

    // Reset holds outputs quiet even with a live store request.
    @(negedge clk); #1;
    chk("reset_mem_write", {31'b0, mem_write}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    @(negedge clk); #1;
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    reset = 1'b0; req_valid = 1'b0;

    // Word store then word load.
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("wst_mem_write", {31'b0, mem_write}, 32'd1);
    chk("wst_mem_addr", mem_addr, 32'h10);
    chk("wst_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wst_stall", {31'b0, stall}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("wld_stall", {31'b0, stall}, 32'd0);
    chk("wld_mem_write", {31'b0, mem_write}, 32'd0);
    idle();
    chk("wld_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("wld_rsp_rdata", rsp_rdata, 32'hDEADBEEF);

    // Byte store merges into the existing word over two cycles.
    drive(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
    chk("bst_c1_stall", {31'b0, stall}, 32'd1);
    chk("bst_c1_mem_write", {31'b0, mem_write}, 32'd0);
    chk("bst_c1_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk); #1;
    chk("bst_c2_mem_write", {31'b0, mem_write}, 32'd1);
    chk("bst_c2_mem_addr", mem_addr, 32'h20);
    chk("bst_c2_mem_wdata", mem_wdata, 32'h1122AA44);
    chk("bst_c2_stall", {31'b0, stall}, 32'd0);
    idle();
    chk("bst_mem", mem[8], 32'h1122AA44);
    chk("bst_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Load extraction and extension from 0x8000FF80.
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h30, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 32'h30, 32'h0);
    chk("ld_sbyte", rsp_rdata, 32'hFFFFFF80);
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
    chk("ld_ubyte", rsp_rdata, 32'h00000080);
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 32'h31, 32'h0);
    chk("ld_shalf_hi", rsp_rdata, 32'hFFFF8000);
    drive(1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 32'h33, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("ld_half_odd", rsp_rdata, 32'h00000000);
`else
    chk("ld_half_odd", rsp_rdata, 32'hFFFFFF80);
`endif
    drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h30, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("ld_size3_word", rsp_rdata, 32'h00000000);
`else
    chk("ld_size3_word", rsp_rdata, 32'h8000FF80);
`endif
    chk("noop_mem_write", {31'b0, mem_write}, 32'd0);
    chk("noop_stall", {31'b0, stall}, 32'd0);
    idle();
    chk("noop_rsp_valid", {31'b0, rsp_valid}, 32'd0);

    // Reset during MERGE_WR aborts the pending write.
    drive(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
    chk("rmw_c1_stall", {31'b0, stall}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rmw_reset_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rmw_reset_stall", {31'b0, stall}, 32'd0);
    idle();
    reset = 1'b0;
    chk("rmw_mem_kept", mem[8], 32'h1122AA44);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("rmw_idle_stall", {31'b0, stall}, 32'd0);
    idle();
    chk("rmw_idle_load", rsp_rdata, 32'h1122AA44);

    // Word store to an unaligned address.
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h41, 32'h12345678);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_mem_write", {31'b0, mem_write}, 32'd0);
    chk("mis_stall", {31'b0, stall}, 32'd0);
    idle();
    chk("mis_pulse", {31'b0, misalign}, 32'd1);
    chk("mis_mem", mem[16], 32'h0);
`else
    chk("mis_mem_write", {31'b0, mem_write}, 32'd1);
    chk("mis_mem_addr", mem_addr, 32'h40);
    idle();
    chk("mis_mem", mem[16], 32'h12345678);
`endif

    // Alternating load / word store: no stalls, one response per load.
    stall_cnt = 0;
    pulse_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      else            drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h50 + 32'(4 * i), 32'(i));
      if (stall) stall_cnt++;
      if (rsp_valid) pulse_cnt++;
    end
    idle();
    if (rsp_valid) pulse_cnt++;
    chk("alt_stall_count", 32'(stall_cnt), 32'd0);
    chk("alt_rsp_pulses", 32'(pulse_cnt), 32'd4);
    chk("alt_last_load", rsp_rdata, 32'hDEADBEEF);
    chk("alt_store_mem", mem[27], 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
